// File: rtl/simd_warp_scheduler.sv
// rtl/simd_warp_scheduler.sv - round-robin warp issue scheduler with per-warp scoreboard
// Optional performance counters enabled by defining SCHED_PERF_CNT_EN.
module simd_warp_scheduler #(
    parameter int NUM_WARPS   = 4,
    parameter int ALU_LATENCY = 1,
    localparam int WID        = $clog2(NUM_WARPS)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    sched_en,
    input  logic [NUM_WARPS-1:0]    req_valid,
    input  logic [16*NUM_WARPS-1:0] req_instr,
    output logic [NUM_WARPS-1:0]    req_ready,
    output logic                    alu_valid,
    output logic [1:0]              alu_op,
    output logic [WID-1:0]          alu_warp,
    output logic                    wb_valid,
    output logic [WID-1:0]          wb_warp,
    output logic [NUM_WARPS-1:0]    busy,
    output logic                    err_illegal,
    output logic [WID-1:0]          err_warp,
    input  logic                    err_clr,
    output logic [31:0]             perf_issue_cnt,
    output logic [31:0]             perf_stall_cnt
);

    logic [WID-1:0]       ptr;
    logic [NUM_WARPS-1:0] eligible;
    logic                 grant_any;
    logic [WID-1:0]       grant_idx;
    logic [15:0]          sel_instr;
    logic                 sel_legal;
    logic                 unused_bits;

    logic [ALU_LATENCY-1:0] pipe_v;
    logic [WID-1:0]         pipe_w [ALU_LATENCY];

    assign eligible = req_valid & ~busy & {NUM_WARPS{sched_en}};

    // First eligible warp at or after ptr, wrapping at NUM_WARPS-1.
    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        for (int i = 0; i < NUM_WARPS; i++) begin
            if (!grant_any && eligible[(int'(ptr) + i) % NUM_WARPS]) begin
                grant_any = 1'b1;
                grant_idx = WID'((int'(ptr) + i) % NUM_WARPS);
            end
        end
    end

    assign req_ready   = grant_any ? (NUM_WARPS'(1) << grant_idx) : '0;
    assign sel_instr   = req_instr[16*grant_idx +: 16];
    assign sel_legal   = ~sel_instr[15];
    assign unused_bits = ^sel_instr[13:0];

    assign wb_valid = pipe_v[ALU_LATENCY-1];
    assign wb_warp  = pipe_w[ALU_LATENCY-1];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr         <= '0;
            alu_valid   <= 1'b0;
            alu_op      <= '0;
            alu_warp    <= '0;
            busy        <= '0;
            err_illegal <= 1'b0;
            err_warp    <= '0;
            pipe_v      <= '0;
            for (int i = 0; i < ALU_LATENCY; i++) pipe_w[i] <= '0;
        end else begin
            alu_valid <= grant_any && sel_legal;
            if (grant_any) begin
                ptr <= (grant_idx == WID'(NUM_WARPS - 1)) ? '0 : grant_idx + 1'b1;
            end
            if (grant_any && sel_legal) begin
                alu_op   <= sel_instr[15:14];
                alu_warp <= grant_idx;
            end

            // A busy warp is never granted, so clear and set never hit the same bit.
            if (wb_valid) busy[wb_warp] <= 1'b0;
            if (grant_any && sel_legal) busy[grant_idx] <= 1'b1;

            pipe_v[0] <= alu_valid;
            pipe_w[0] <= alu_warp;
            for (int i = 1; i < ALU_LATENCY; i++) begin
                pipe_v[i] <= pipe_v[i-1];
                pipe_w[i] <= pipe_w[i-1];
            end

            // A new illegal op overrides a simultaneous clear.
            if (grant_any && !sel_legal) begin
                err_illegal <= 1'b1;
                if (!err_illegal || err_clr) err_warp <= grant_idx;
            end else if (err_clr) begin
                err_illegal <= 1'b0;
                err_warp    <= '0;
            end
        end
    end

`ifdef SCHED_PERF_CNT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_issue_cnt <= '0;
            perf_stall_cnt <= '0;
        end else begin
            if (alu_valid) perf_issue_cnt <= perf_issue_cnt + 32'd1;
            if (|req_valid && !grant_any) perf_stall_cnt <= perf_stall_cnt + 32'd1;
        end
    end
`else
    assign perf_issue_cnt = '0;
    assign perf_stall_cnt = '0;
`endif

endmodule

// File: tb/tb_simd_warp_scheduler.sv
// tb/tb_simd_warp_scheduler.sv - directed self-checking bench for simd_warp_scheduler
module tb_simd_warp_scheduler;

    localparam int NW = 4;
    localparam int L  = 2;

    logic          clk;
    logic          reset;
    logic          sched_en;
    logic [NW-1:0] req_valid;
    logic [63:0]   req_instr;
    logic [NW-1:0] req_ready;
    logic          alu_valid;
    logic [1:0]    alu_op;
    logic [1:0]    alu_warp;
    logic          wb_valid;
    logic [1:0]    wb_warp;
    logic [NW-1:0] busy;
    logic          err_illegal;
    logic [1:0]    err_warp;
    logic          err_clr;
    logic [31:0]   perf_issue_cnt;
    logic [31:0]   perf_stall_cnt;

    int compared = 0;
    int mismatched = 0;

    simd_warp_scheduler #(.NUM_WARPS(NW), .ALU_LATENCY(L)) dut (
        .clk(clk), .reset(reset), .sched_en(sched_en),
        .req_valid(req_valid), .req_instr(req_instr), .req_ready(req_ready),
        .alu_valid(alu_valid), .alu_op(alu_op), .alu_warp(alu_warp),
        .wb_valid(wb_valid), .wb_warp(wb_warp), .busy(busy),
        .err_illegal(err_illegal), .err_warp(err_warp), .err_clr(err_clr),
        .perf_issue_cnt(perf_issue_cnt), .perf_stall_cnt(perf_stall_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic settle;
        #2;
    endtask

    task automatic do_reset;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1; sched_en = 1'b1; req_valid = '0; req_instr = '0; err_clr = 1'b0;
        #12;
        compared++;
        if ({req_ready, alu_valid, alu_op, alu_warp, wb_valid, wb_warp} !== 12'd0) begin
            mismatched++;
            $display("FAIL reset_outputs: got %b expected 0",
                     {req_ready, alu_valid, alu_op, alu_warp, wb_valid, wb_warp});
        end
        compared++;
        if ({busy, err_illegal, err_warp} !== 7'd0) begin
            mismatched++;
            $display("FAIL reset_state: got %b expected 0", {busy, err_illegal, err_warp});
        end
        compared++;
        if ({perf_issue_cnt, perf_stall_cnt} !== 64'd0) begin
            mismatched++;
            $display("FAIL reset_perf: got %h expected 0", {perf_issue_cnt, perf_stall_cnt});
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_single_issue;
        do_reset();
        req_valid = 4'b0001; req_instr = '0;
        settle();
        compared++;
        if (req_ready !== 4'b0001) begin
            mismatched++; $display("FAIL single_grant: got %b expected 0001", req_ready);
        end
        tick();
        req_valid = '0;
        settle();
        compared++;
        if ({alu_valid, alu_op, alu_warp, busy} !== {1'b1, 2'b00, 2'd0, 4'b0001}) begin
            mismatched++;
            $display("FAIL single_issue: got %b expected 1_00_00_0001", {alu_valid, alu_op, alu_warp, busy});
        end
        tick();
        settle();
        compared++;
        if ({alu_valid, wb_valid, busy} !== {1'b0, 1'b0, 4'b0001}) begin
            mismatched++; $display("FAIL single_c2: got %b expected 0_0_0001", {alu_valid, wb_valid, busy});
        end
        tick();
        settle();
        compared++;
        if ({wb_valid, wb_warp, busy} !== {1'b1, 2'd0, 4'b0001}) begin
            mismatched++; $display("FAIL single_wb: got %b expected 1_00_0001", {wb_valid, wb_warp, busy});
        end
        tick();
        settle();
        compared++;
        if ({wb_valid, busy} !== 5'b0_0000) begin
            mismatched++; $display("FAIL single_release: got %b expected 0_0000", {wb_valid, busy});
        end
    endtask

    task automatic test_round_robin;
        logic [3:0] exp_rdy;
        do_reset();
        req_valid = 4'b1111;
        req_instr = {4{16'h4000}};
        for (int c = 0; c < 9; c++) begin
            settle();
            exp_rdy = 4'(1 << (c % 4));
            compared++;
            if (req_ready !== exp_rdy) begin
                mismatched++; $display("FAIL rr_grant_c%0d: got %b expected %b", c, req_ready, exp_rdy);
            end
            if (c >= 1) begin
                compared++;
                if ({alu_valid, alu_op, alu_warp} !== {1'b1, 2'b01, 2'((c - 1) % 4)}) begin
                    mismatched++;
                    $display("FAIL rr_issue_c%0d: got %b expected 1_01_%0d", c, {alu_valid, alu_op, alu_warp}, (c - 1) % 4);
                end
            end
            tick();
        end
        req_valid = '0;
    endtask

    task automatic test_illegal;
        do_reset();
        req_valid = 4'b0100; req_instr = '0; req_instr[47:32] = 16'h8000;
        settle();
        compared++;
        if (req_ready !== 4'b0100) begin
            mismatched++; $display("FAIL ill_consume: got %b expected 0100", req_ready);
        end
        tick();
        req_valid = '0;
        settle();
        compared++;
        if ({alu_valid, busy, err_illegal, err_warp} !== {1'b0, 4'b0000, 1'b1, 2'd2}) begin
            mismatched++;
            $display("FAIL ill_flag: got %b expected 0_0000_1_10", {alu_valid, busy, err_illegal, err_warp});
        end
        req_valid = 4'b0010; req_instr[31:16] = 16'hC000;
        settle();
        compared++;
        if (req_ready !== 4'b0010) begin
            mismatched++; $display("FAIL ill_second_grant: got %b expected 0010", req_ready);
        end
        tick();
        req_valid = '0;
        settle();
        compared++;
        if ({err_illegal, err_warp} !== {1'b1, 2'd2}) begin
            mismatched++; $display("FAIL ill_sticky: got %b expected 1_10", {err_illegal, err_warp});
        end
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        settle();
        compared++;
        if (err_illegal !== 1'b0) begin
            mismatched++; $display("FAIL ill_clear: got %b expected 0", err_illegal);
        end
        // Set the flag, then clear and raise a new error in the same cycle.
        req_valid = 4'b0010;
        tick();
        req_valid = 4'b1000; req_instr[63:48] = 16'h8000; err_clr = 1'b1;
        tick();
        req_valid = '0; err_clr = 1'b0;
        settle();
        compared++;
        if ({err_illegal, err_warp} !== {1'b1, 2'd3}) begin
            mismatched++; $display("FAIL ill_clr_collide: got %b expected 1_11", {err_illegal, err_warp});
        end
    endtask

    task automatic test_sched_disable;
        do_reset();
        req_valid = 4'b0001; req_instr = '0;
        settle();
        compared++;
        if (req_ready !== 4'b0001) begin
            mismatched++; $display("FAIL dis_first_grant: got %b expected 0001", req_ready);
        end
        tick();
        sched_en = 1'b0; req_valid = 4'b1111;
        for (int c = 1; c < 7; c++) begin
            settle();
            compared++;
            if (req_ready !== 4'b0000) begin
                mismatched++; $display("FAIL dis_ready_c%0d: got %b expected 0000", c, req_ready);
            end
            compared++;
            if (wb_valid !== (c == 3)) begin
                mismatched++; $display("FAIL dis_wb_c%0d: got %b expected %b", c, wb_valid, c == 3);
            end
            tick();
        end
        sched_en = 1'b1; req_valid = '0;
    endtask

    task automatic test_reset_midflight;
        do_reset();
        req_valid = 4'b0011; req_instr = '0;
        tick();
        tick();
        req_valid = '0;
        do_reset();
        for (int c = 0; c < 2 * L; c++) begin
            settle();
            compared++;
            if ({wb_valid, busy} !== 5'd0) begin
                mismatched++; $display("FAIL rst_drain_c%0d: got %b expected 0_0000", c, {wb_valid, busy});
            end
            tick();
        end
        req_valid = 4'b1111;
        settle();
        compared++;
        if (req_ready !== 4'b0001) begin
            mismatched++; $display("FAIL rst_first_grant: got %b expected 0001", req_ready);
        end
        tick();
        req_valid = '0;
    endtask

    task automatic test_perf;
        do_reset();
        req_valid = 4'b1111; req_instr = '0; sched_en = 1'b1;
        repeat (10) tick();
        req_valid = '0;
        repeat (2) tick();
        sched_en = 1'b0; req_valid = 4'b0001;
        repeat (3) tick();
        sched_en = 1'b1; req_valid = '0;
        settle();
`ifdef SCHED_PERF_CNT_EN
        compared++;
        if (perf_issue_cnt !== 32'd10) begin
            mismatched++; $display("FAIL perf_issue: got %0d expected 10", perf_issue_cnt);
        end
        compared++;
        if (perf_stall_cnt !== 32'd3) begin
            mismatched++; $display("FAIL perf_stall: got %0d expected 3", perf_stall_cnt);
        end
`else
        compared++;
        if ({perf_issue_cnt, perf_stall_cnt} !== 64'd0) begin
            mismatched++; $display("FAIL perf_tied: got %h expected 0", {perf_issue_cnt, perf_stall_cnt});
        end
`endif
    endtask

    initial begin
        test_reset();
        test_single_issue();
        test_round_robin();
        test_illegal();
        test_sched_disable();
        test_reset_midflight();
        test_perf();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
